// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set controller for the digital clock.
// Synchronises the MODE/INC buttons, steps RUN -> SET_HOUR -> SET_MIN -> RUN,
// issues registered increment / seconds-clear pulses with hold-to-repeat,
// returns to RUN after a period of inactivity and blinks the field being set.
module clock_set_ctrl #(
  parameter int HOLD_CYC      = 25_000_000,
  parameter int REPEAT_CYC    = 5_000_000,
  parameter int BLINK_CYC     = 12_500_000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       cnt_en,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       sec_clr,
  output logic       blink_min,
  output logic       blink_hour,
  output logic [1:0] mode
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam int BLINK_W = $clog2(BLINK_CYC + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_TICKS + 1);

  // After a repeat pulse the hold counter is rewound so that it climbs back to
  // HOLD_CYC in exactly REPEAT_CYC cycles; it therefore never exceeds HOLD_CYC.
  // A REPEAT_CYC larger than HOLD_CYC degrades to a HOLD_CYC repeat interval.
  localparam int HOLD_RELOAD_I = (REPEAT_CYC <= HOLD_CYC) ? (HOLD_CYC - REPEAT_CYC + 1) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_MAX    = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(HOLD_RELOAD_I);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT_TICKS - 1);

  logic [1:0]         mode_sync_q, mode_sync_d;
  logic               mode_prev_q, mode_prev_d;
  logic               mode_edge_q, mode_edge_d;
  logic [1:0]         inc_sync_q, inc_sync_d;
  logic               inc_prev_q, inc_prev_d;
  logic               inc_edge_q, inc_edge_d;
  logic [1:0]         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               phase_q, phase_d;
  logic               inc_min_q, inc_min_d;
  logic               inc_hour_q, inc_hour_d;
  logic               sec_clr_q, sec_clr_d;

  logic in_set;
  logic mode_ev;
  logic inc_ev;
  logic rpt_fire;
  logic tmo_hit;
  logic inc_req;

  // Next-state logic: button conditioning, FSM, hold/repeat, timeout, blink.
  always_comb begin
    // Two sync flops, a previous-value flop, then a registered rising edge.
    mode_sync_d = {mode_sync_q[0], btn_mode};
    mode_prev_d = mode_sync_q[1];
    mode_edge_d = mode_sync_q[1] & ~mode_prev_q;
    inc_sync_d  = {inc_sync_q[0], btn_inc};
    inc_prev_d  = inc_sync_q[1];
    inc_edge_d  = inc_sync_q[1] & ~inc_prev_q;

    in_set  = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
    // MODE has priority: a coincident INC edge is dropped.
    mode_ev = mode_edge_q;
    inc_ev  = inc_edge_q & in_set & ~mode_ev;

    // inc_prev_q is the held level aligned with inc_edge_q.
    rpt_fire = in_set & inc_prev_q & ~mode_ev & (hold_q == HOLD_MAX);
    hold_d   = hold_q;
    if (!in_set || !inc_prev_q || mode_ev) begin
      hold_d = '0;
    end else if (rpt_fire) begin
      hold_d = HOLD_RELOAD;
    end else if (hold_q < HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
    end

    // Any button activity defers the inactivity timeout.
    tmo_hit = in_set & tick_1hz & (tmo_q == TMO_LAST) & ~mode_ev & ~inc_ev & ~rpt_fire;
    tmo_d   = tmo_q;
    if (!in_set || mode_ev || inc_ev || rpt_fire || tmo_hit) begin
      tmo_d = '0;
    end else if (tick_1hz) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    inc_req = inc_ev | rpt_fire;

    state_d = ST_RUN;
    case (state_q)
      ST_RUN:      state_d = mode_ev ? ST_SET_HOUR : ST_RUN;
      ST_SET_HOUR: state_d = mode_ev ? ST_SET_MIN  : (tmo_hit ? ST_RUN : ST_SET_HOUR);
      ST_SET_MIN:  state_d = (mode_ev || tmo_hit) ? ST_RUN : ST_SET_MIN;
      default:     state_d = ST_RUN;
    endcase

    sec_clr_d  = (state_q == ST_SET_MIN) & mode_ev;
    inc_hour_d = (state_q == ST_SET_HOUR) & inc_req;
    inc_min_d  = (state_q == ST_SET_MIN) & inc_req;

    // Blink restarts visible on entry to a set state and on every increment.
    blink_d = blink_q + BLINK_W'(1);
    phase_d = phase_q;
    if ((state_d != ST_SET_HOUR && state_d != ST_SET_MIN) || (state_d != state_q) || inc_req) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end
  end

  // State and pulse registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sync_q <= '0;
      mode_prev_q <= 1'b0;
      mode_edge_q <= 1'b0;
      inc_sync_q  <= '0;
      inc_prev_q  <= 1'b0;
      inc_edge_q  <= 1'b0;
      state_q     <= ST_RUN;
      hold_q      <= '0;
      tmo_q       <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_hour_q  <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      mode_sync_q <= mode_sync_d;
      mode_prev_q <= mode_prev_d;
      mode_edge_q <= mode_edge_d;
      inc_sync_q  <= inc_sync_d;
      inc_prev_q  <= inc_prev_d;
      inc_edge_q  <= inc_edge_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      inc_min_q   <= inc_min_d;
      inc_hour_q  <= inc_hour_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  // Output decode; the unused encoding 11 reads as RUN.
  always_comb begin
    mode       = (state_q == 2'b11) ? ST_RUN : state_q;
    cnt_en     = (state_q == ST_RUN) || (state_q == 2'b11);
    inc_min    = inc_min_q;
    inc_hour   = inc_hour_q;
    sec_clr    = sec_clr_q;
    blink_hour = (state_q == ST_SET_HOUR) & phase_q;
    blink_min  = (state_q == ST_SET_MIN) & phase_q;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small timing parameters.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       cnt_en;
  logic       inc_min;
  logic       inc_hour;
  logic       sec_clr;
  logic       blink_min;
  logic       blink_hour;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  int pulses;

  clock_set_ctrl #(
    .HOLD_CYC(8),
    .REPEAT_CYC(4),
    .BLINK_CYC(3),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .cnt_en(cnt_en),
    .inc_min(inc_min),
    .inc_hour(inc_hour),
    .sec_clr(sec_clr),
    .blink_min(blink_min),
    .blink_hour(blink_hour),
    .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MODE press: first sampled at edge k, ends just after edge k+3 where the
  // registered outputs reflect the press.
  task automatic mode_press(input string tag, input logic [1:0] exp_mode, input logic exp_sc);
    btn_mode = 1'b1;
    tick();
    tick();
    btn_mode = 1'b0;
    tick();
    chk({tag, "_sc_early"}, sec_clr, 0);
    tick();
    chk({tag, "_mode"}, mode, exp_mode);
    chk({tag, "_sc"}, sec_clr, exp_sc);
  endtask

  task automatic one_sec();
    tick_1hz = 1'b1;
    tick();
    tick_1hz = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) tick();
    chk("rst_mode", mode, 0);
    chk("rst_cnt_en", cnt_en, 1);
    chk("rst_inc_min", inc_min, 0);
    chk("rst_inc_hour", inc_hour, 0);
    chk("rst_sec_clr", sec_clr, 0);
    chk("rst_blink", {blink_hour, blink_min}, 0);
    rst = 1'b0;
    tick(); tick();

    // Three MODE presses walk the full cycle.
    mode_press("m1", 2'b01, 1'b0);
    chk("m1_cnt_en", cnt_en, 0);
    tick(); tick();
    mode_press("m2", 2'b10, 1'b0);
    chk("m2_cnt_en", cnt_en, 0);
    tick(); tick();
    mode_press("m3", 2'b00, 1'b1);
    chk("m3_cnt_en", cnt_en, 1);
    tick();
    chk("m3_sc_once", sec_clr, 0);
    tick(); tick();

    // Blink in SET_HOUR: 3 cycles visible, 3 blanked, repeating.
    mode_press("b_enter", 2'b01, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk($sformatf("blink_hour_%0d", i), blink_hour, ((i / 3) % 2));
      chk($sformatf("blink_min_%0d", i), blink_min, 0);
    end
    mode_press("b_min", 2'b10, 1'b0);
    chk("blink_min_entry", blink_min, 0);
    tick(); tick(); tick();
    chk("blink_min_on", blink_min, 1);
    chk("blink_hour_off", blink_hour, 0);

    // Hold INC for 20 cycles in SET_MIN: pulses at +3, +11, +15, +19.
    pulses = 0;
    btn_inc = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk($sformatf("hold_inc_min_%0d", c), inc_min,
          ((c == 4) || (c == 12) || (c == 16) || (c == 20)) ? 1 : 0);
      chk($sformatf("hold_inc_hour_%0d", c), inc_hour, 0);
      if (inc_min) pulses++;
      if (c == 20) btn_inc = 1'b0;
    end
    chk("hold_total", pulses[7:0], 4);
    tick(); tick();
    mode_press("h_exit", 2'b00, 1'b1);
    tick(); tick();

    // INC in RUN is ignored.
    pulses = 0;
    btn_inc = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 10) btn_inc = 1'b0;
      if (inc_min || inc_hour) pulses++;
    end
    chk("run_inc_pulses", pulses[7:0], 0);
    chk("run_inc_mode", mode, 0);

    // MODE and INC rise together in SET_HOUR: MODE wins.
    mode_press("mi_enter", 2'b01, 1'b0);
    tick(); tick();
    btn_mode = 1'b1; btn_inc = 1'b1;
    tick(); tick();
    btn_mode = 1'b0; btn_inc = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (inc_min || inc_hour) pulses++;
    end
    chk("mi_mode", mode, 2'b10);
    chk("mi_pulses", pulses[7:0], 0);
    mode_press("mi_exit", 2'b00, 1'b1);
    tick(); tick();

    // Timeout in SET_HOUR; an INC press restarts the count.
    mode_press("to_enter", 2'b01, 1'b0);
    tick(); tick();
    one_sec();
    one_sec();
    chk("to_two_ticks", mode, 2'b01);
    btn_inc = 1'b1;
    tick(); tick();
    btn_inc = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (inc_hour) pulses++;
    end
    chk("to_inc_pulse", pulses[7:0], 1);
    one_sec();
    one_sec();
    chk("to_restarted", mode, 2'b01);
    tick_1hz = 1'b1;
    tick();
    tick_1hz = 1'b0;
    chk("to_mode", mode, 2'b00);
    chk("to_cnt_en", cnt_en, 1);
    chk("to_sc", sec_clr, 0);
    chk("to_inc", {inc_hour, inc_min}, 0);
    tick();
    chk("to_sc_next", sec_clr, 0);
    tick(); tick();

    // Asynchronous reset mid-set with INC held.
    mode_press("r_h", 2'b01, 1'b0);
    tick(); tick();
    mode_press("r_m", 2'b10, 1'b0);
    tick(); tick();
    btn_inc = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rmid_mode", mode, 0);
    chk("rmid_cnt_en", cnt_en, 1);
    chk("rmid_inc", {inc_hour, inc_min}, 0);
    tick(); tick();
    chk("rmid_inc_held", {inc_hour, inc_min}, 0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (inc_min || inc_hour || sec_clr) pulses++;
    end
    chk("rpost_pulses", pulses[7:0], 0);
    chk("rpost_mode", mode, 0);
    btn_inc = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
